// File: rtl/alu_muldiv_if.sv
// Bus bundle between the execute stage and the ALU / mult-div unit.
// master: drives the operation code, operands, shift amount and MdValid.
// slave : drives Result, Zero, BranchTaken, Stall, MdDone, Hi and Lo.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [4:0]       AluCtrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       Shamt;
  logic             MdValid;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             BranchTaken;
  logic             Stall;
  logic             MdDone;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output AluCtrl, A, B, Shamt, MdValid,
    input  Result, Zero, BranchTaken, Stall, MdDone, Hi, Lo
  );

  modport slave (
    input  AluCtrl, A, B, Shamt, MdValid,
    output Result, Zero, BranchTaken, Stall, MdDone, Hi, Lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage ALU for the single-cycle MIPS datapath.
// Single-cycle operations are purely combinational; mult/div run on an
// iterative 32-step engine on operand magnitudes that writes HI/LO and
// holds the PC/IR through Stall until the result is ready.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset (clears HI/LO and the engine)
//   bus   - slave side of alu_muldiv_if (AluCtrl, A, B, Shamt, MdValid in;
//           Result, Zero, BranchTaken, Stall, MdDone, Hi, Lo out)
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_muldiv_if.slave   bus
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_MULT = 5'b01001;
  localparam logic [4:0] OP_MFHI = 5'b01010;
  localparam logic [4:0] OP_SLLV = 5'b01011;
  localparam logic [4:0] OP_SRLV = 5'b01100;
  localparam logic [4:0] OP_LUI  = 5'b01101;
  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_NOR  = 5'b01111;
  localparam logic [4:0] OP_BNE  = 5'b10000;
  localparam logic [4:0] OP_BLEZ = 5'b10001;
  localparam logic [4:0] OP_BGTZ = 5'b10010;
  localparam logic [4:0] OP_MFLO = 5'b10011;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [4:0]       count_reg, count_next;
  logic             op_div_reg, op_div_next;
  logic             neg_res_reg, neg_res_next;   // product sign / quotient sign
  logic             neg_a_reg, neg_a_next;       // remainder takes the dividend sign
  logic             div_zero_reg, div_zero_next;
  logic [WIDTH-1:0] a_raw_reg, a_raw_next;       // original dividend for divide-by-zero
  logic [WIDTH-1:0] b_mag_reg, b_mag_next;       // |B|: multiplicand or divisor
  logic [WIDTH-1:0] work_hi_reg, work_hi_next;   // partial product high / remainder
  logic [WIDTH-1:0] work_lo_reg, work_lo_next;   // multiplier / dividend-quotient
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             md_done_reg, md_done_next;

  logic             is_md;
  logic             is_hilo_rd;
  logic             busy;
  logic             last_step;
  logic             issue;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;

  logic [WIDTH-1:0] result;
  logic             branch_taken;

  // ---------------------------------------------------------------------------
  // Decode and engine status
  // ---------------------------------------------------------------------------
  assign is_md      = (bus.AluCtrl == OP_MULT) || (bus.AluCtrl == OP_DIV);
  assign is_hilo_rd = (bus.AluCtrl == OP_MFHI) || (bus.AluCtrl == OP_MFLO);
  assign busy       = (state_reg == RUN);
  assign last_step  = busy && (count_reg == 5'd31);
  assign issue      = (state_reg == IDLE) && bus.MdValid && is_md;

  assign a_mag = bus.A[WIDTH-1] ? ('0 - bus.A) : bus.A;
  assign b_mag = bus.B[WIDTH-1] ? ('0 - bus.B) : bus.B;

  // ---------------------------------------------------------------------------
  // One iteration of the engine. Both algorithms shift a {work_hi, work_lo}
  // pair; mult shifts right (shift-add), div shifts left (restoring).
  // ---------------------------------------------------------------------------
  always_comb begin
    mul_sum  = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, b_mag_reg} : '0);
    div_sh   = {work_hi_reg, work_lo_reg[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_mag_reg};
    step_hi  = '0;
    step_lo  = '0;
    if (op_div_reg) begin
      // A negative trial difference means the divisor did not fit: restore.
      step_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {work_lo_reg[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
    end
  end

  // Sign correction applied to the final magnitudes when HI/LO are written.
  always_comb begin
    prod_mag    = {step_hi, step_lo};
    prod_signed = neg_res_reg ? ('0 - prod_mag) : prod_mag;
    fin_hi      = prod_signed[2*WIDTH-1:WIDTH];
    fin_lo      = prod_signed[WIDTH-1:0];
    if (op_div_reg) begin
      if (div_zero_reg) begin
        fin_hi = a_raw_reg;
        fin_lo = '1;
      end else begin
        // 0x80000000 / -1 falls out naturally: magnitude 2^31, positive sign.
        fin_lo = neg_res_reg ? ('0 - step_lo) : step_lo;
        fin_hi = neg_a_reg   ? ('0 - step_hi) : step_hi;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Engine FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      op_div_reg   <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_a_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      a_raw_reg    <= '0;
      b_mag_reg    <= '0;
      work_hi_reg  <= '0;
      work_lo_reg  <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      md_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      op_div_reg   <= op_div_next;
      neg_res_reg  <= neg_res_next;
      neg_a_reg    <= neg_a_next;
      div_zero_reg <= div_zero_next;
      a_raw_reg    <= a_raw_next;
      b_mag_reg    <= b_mag_next;
      work_hi_reg  <= work_hi_next;
      work_lo_reg  <= work_lo_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      md_done_reg  <= md_done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Engine FSM: next state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    op_div_next   = op_div_reg;
    neg_res_next  = neg_res_reg;
    neg_a_next    = neg_a_reg;
    div_zero_next = div_zero_reg;
    a_raw_next    = a_raw_reg;
    b_mag_next    = b_mag_reg;
    work_hi_next  = work_hi_reg;
    work_lo_next  = work_lo_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    md_done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          state_next    = RUN;
          count_next    = '0;
          op_div_next   = (bus.AluCtrl == OP_DIV);
          neg_res_next  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
          neg_a_next    = bus.A[WIDTH-1];
          div_zero_next = (bus.B == '0);
          a_raw_next    = bus.A;
          b_mag_next    = b_mag;
          work_hi_next  = '0;
          work_lo_next  = a_mag;
        end
      end
      RUN: begin
        work_hi_next = step_hi;
        work_lo_next = step_lo;
        count_next   = count_reg + 5'd1;
        if (count_reg == 5'd31) begin
          state_next   = IDLE;
          count_next   = '0;
          hi_next      = fin_hi;
          lo_next      = fin_lo;
          md_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Combinational ALU result
  // ---------------------------------------------------------------------------
  always_comb begin
    result = '0;
    case (bus.AluCtrl)
      OP_AND:  result = bus.A & bus.B;
      OP_OR:   result = bus.A | bus.B;
      OP_ADD:  result = bus.A + bus.B;
      OP_SUB:  result = bus.A - bus.B;
      OP_XOR:  result = bus.A ^ bus.B;
      OP_NOR:  result = ~(bus.A | bus.B);
      OP_SLL:  result = bus.B << bus.Shamt;
      OP_SRL:  result = bus.B >> bus.Shamt;
      OP_SRA:  result = $signed(bus.B) >>> bus.Shamt;
      OP_SLLV: result = bus.B << bus.A[4:0];
      OP_SRLV: result = bus.B >> bus.A[4:0];
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_LUI:  result = {bus.B[15:0], 16'h0000};
      OP_MFHI: result = hi_reg;
      OP_MFLO: result = lo_reg;
      OP_BNE:  result = bus.A - bus.B;
      OP_BLEZ: result = bus.A;
      OP_BGTZ: result = bus.A;
      default: result = '0;
    endcase
  end

  // sub shares the beq code, so it also reports equality; Branch gates it.
  always_comb begin
    branch_taken = 1'b0;
    case (bus.AluCtrl)
      OP_SUB:  branch_taken = (bus.A == bus.B);
      OP_BNE:  branch_taken = (bus.A != bus.B);
      OP_BLEZ: branch_taken = ($signed(bus.A) <= 0);
      OP_BGTZ: branch_taken = ($signed(bus.A) > 0);
      default: branch_taken = 1'b0;
    endcase
  end

  // The issuing mult/div releases the hold in the final RUN cycle so it
  // retires exactly once; HI/LO readers wait until the MdDone cycle.
  assign bus.Stall       = (is_md && bus.MdValid && !last_step) || (is_hilo_rd && busy);
  assign bus.Result      = result;
  assign bus.Zero        = (result == '0);
  assign bus.BranchTaken = branch_taken;
  assign bus.MdDone      = md_done_reg;
  assign bus.Hi          = hi_reg;
  assign bus.Lo          = lo_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: a behavioural model checked every
// cycle, plus hand-computed literal expectations for directed cases.
module tb_alu_muldiv;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_MULT = 5'b01001;
  localparam logic [4:0] OP_MFHI = 5'b01010;
  localparam logic [4:0] OP_SLLV = 5'b01011;
  localparam logic [4:0] OP_SRLV = 5'b01100;
  localparam logic [4:0] OP_LUI  = 5'b01101;
  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_NOR  = 5'b01111;
  localparam logic [4:0] OP_BNE  = 5'b10000;
  localparam logic [4:0] OP_BLEZ = 5'b10001;
  localparam logic [4:0] OP_BGTZ = 5'b10010;
  localparam logic [4:0] OP_MFLO = 5'b10011;

  logic clk = 1'b0;
  logic reset;
  logic run_cmp = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  alu_muldiv_if bus();

  alu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  logic        m_busy, m_done;
  int          m_steps;

  function automatic logic is_md(input logic [4:0] c);
    return (c == OP_MULT) || (c == OP_DIV);
  endfunction

  function automatic logic is_hilo(input logic [4:0] c);
    return (c == OP_MFHI) || (c == OP_MFLO);
  endfunction

  function automatic logic [31:0] exp_result(input logic [4:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh,
                                             input logic [31:0] hi, input logic [31:0] lo);
    int sa, sb;
    sa = a;
    sb = b;
    case (c)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_BNE:  return a - b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLL:  return b * (32'd1 << sh);
      OP_SRL:  return b / (32'd1 << sh);
      OP_SRA:  return 32'(sb >>> sh);
      OP_SLLV: return b * (32'd1 << a[4:0]);
      OP_SRLV: return b / (32'd1 << a[4:0]);
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_LUI:  return b * 32'h0001_0000;
      OP_MFHI: return hi;
      OP_MFLO: return lo;
      OP_BLEZ: return a;
      OP_BGTZ: return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_branch(input logic [4:0] c, input logic [31:0] a,
                                      input logic [31:0] b);
    int sa;
    sa = a;
    case (c)
      OP_SUB:  return a == b;
      OP_BNE:  return a != b;
      OP_BLEZ: return sa <= 0;
      OP_BGTZ: return sa > 0;
      default: return 1'b0;
    endcase
  endfunction

  // Returns {HI, LO} for a mult or div.
  function automatic logic [63:0] md_model(input logic div_op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] p;
    int ia, ib, q, r;
    ia = a;
    ib = b;
    if (!div_op) begin
      p = 64'(ia) * 64'(ib);
      return p;
    end
    if (ib == 0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && ib == -1) return {32'h0, 32'h8000_0000};
    q = ia / ib;
    r = ia % ib;
    return {32'(r), 32'(q)};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi    <= 32'd0;
      m_lo    <= 32'd0;
      m_pend  <= 64'd0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_steps <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_steps == 31) begin
          m_busy <= 1'b0;
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end else begin
          m_steps <= m_steps + 1;
        end
      end else if (bus.MdValid && is_md(bus.AluCtrl)) begin
        m_busy  <= 1'b1;
        m_steps <= 0;
        m_pend  <= md_model(bus.AluCtrl == OP_DIV, bus.A, bus.B);
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      check_val("result", bus.Result,
                exp_result(bus.AluCtrl, bus.A, bus.B, bus.Shamt, m_hi, m_lo));
      check_val("zero", 32'(bus.Zero),
                32'(exp_result(bus.AluCtrl, bus.A, bus.B, bus.Shamt, m_hi, m_lo) == 32'd0));
      check_val("branch", 32'(bus.BranchTaken), 32'(exp_branch(bus.AluCtrl, bus.A, bus.B)));
      check_val("stall", 32'(bus.Stall),
                32'((is_md(bus.AluCtrl) && bus.MdValid && !(m_busy && m_steps == 31)) ||
                    (is_hilo(bus.AluCtrl) && m_busy)));
      check_val("mddone", 32'(bus.MdDone), 32'(m_done));
      check_val("hi", bus.Hi, m_hi);
      check_val("lo", bus.Lo, m_lo);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic v);
    @(posedge clk);
    #1;
    bus.AluCtrl = c;
    bus.A       = a;
    bus.B       = b;
    bus.Shamt   = sh;
    bus.MdValid = v;
  endtask

  task automatic alu_case(input string name, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
    drive(c, a, b, sh, 1'b0);
    @(negedge clk);
    check_val(name, bus.Result, exp);
    $display("alu %s ctrl=%b A=%h B=%h -> %h", name, c, a, b, bus.Result);
  endtask

  // Issue a mult/div held like a stalled IR, then read it back via mflo.
  task automatic md_case(input string name, input logic [4:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int  n_stall;
    logic done;
    n_stall = 0;
    done    = 1'b0;
    drive(c, a, b, 5'd0, 1'b1);
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus.Stall) n_stall++;
      else done = 1'b1;
    end
    check_val({name, "_finished"}, 32'(done), 32'd1);
    check_val({name, "_stall_cycles"}, 32'(n_stall), 32'd32);
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    check_val({name, "_mddone"}, 32'(bus.MdDone), 32'd1);
    check_val({name, "_hi"}, bus.Hi, exp_hi);
    check_val({name, "_lo"}, bus.Lo, exp_lo);
    check_val({name, "_mflo"}, bus.Result, exp_lo);
    $display("md %s A=%h B=%h -> Hi=%h Lo=%h stall=%0d", name, a, b, bus.Hi, bus.Lo, n_stall);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'd0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    case ($urandom_range(0, 18))
      0: return OP_AND;   1: return OP_OR;    2: return OP_ADD;   3: return OP_SUB;
      4: return OP_XOR;   5: return OP_NOR;   6: return OP_SLL;   7: return OP_SRL;
      8: return OP_SRA;   9: return OP_SLLV;  10: return OP_SRLV; 11: return OP_SLT;
      12: return OP_LUI;  13: return OP_MFHI; 14: return OP_MFLO; 15: return OP_BNE;
      16: return OP_BLEZ; 17: return OP_BGTZ; default: return ($urandom_range(0, 1) != 0) ? OP_MULT : OP_DIV;
    endcase
  endfunction

  initial begin
    int  n_stall;
    logic done;
    logic hold;

    reset       = 1'b0;
    bus.AluCtrl = OP_AND;
    bus.A       = 32'd0;
    bus.B       = 32'd0;
    bus.Shamt   = 5'd0;
    bus.MdValid = 1'b0;
    #1 reset = 1'b1;
    #2;
    check_val("reset_hi", bus.Hi, 32'd0);
    check_val("reset_lo", bus.Lo, 32'd0);
    check_val("reset_mddone", 32'(bus.MdDone), 32'd0);
    check_val("reset_stall", 32'(bus.Stall), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    run_cmp = 1'b1;

    // ALU sweep and spot checks
    alu_case("and",  OP_AND, 32'hF0F0_F0F0, 32'h0000_FFFF, 5'd0, 32'h0000_F0F0);
    alu_case("or",   OP_OR,  32'hF0F0_F0F0, 32'h0000_FFFF, 5'd0, 32'hF0F0_FFFF);
    alu_case("nor",  OP_NOR, 32'hF0F0_F0F0, 32'h0000_FFFF, 5'd0, 32'h0F0F_0000);
    alu_case("xor",  OP_XOR, 32'hF0F0_F0F0, 32'h0000_FFFF, 5'd0, 32'hF0F0_0F0F);
    alu_case("lui",  OP_LUI, 32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000);
    alu_case("sra",  OP_SRA, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000);
    alu_case("slt",  OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);

    // Branches
    drive(OP_SUB, 32'd9, 32'd9, 5'd0, 1'b0);
    @(negedge clk);
    check_val("beq_taken", 32'(bus.BranchTaken), 32'd1);
    check_val("beq_zero", 32'(bus.Zero), 32'd1);
    drive(OP_BNE, 32'd9, 32'd9, 5'd0, 1'b0);
    @(negedge clk);
    check_val("bne_taken", 32'(bus.BranchTaken), 32'd0);
    drive(OP_BLEZ, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    check_val("blez_zero", 32'(bus.BranchTaken), 32'd1);
    drive(OP_BGTZ, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    check_val("bgtz_zero", 32'(bus.BranchTaken), 32'd0);
    drive(OP_BGTZ, 32'h8000_0000, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    check_val("bgtz_min", 32'(bus.BranchTaken), 32'd0);

    // mult/div engine
    md_case("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    md_case("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_case("div_by0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    md_case("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // mfhi presented while the engine is busy
    drive(OP_MULT, 32'h0001_0000, 32'h0003_0000, 5'd0, 1'b1);
    @(negedge clk);
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b0);
    n_stall = 0;
    done    = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus.Stall) n_stall++;
      else done = 1'b1;
    end
    check_val("mfhi_busy_finished", 32'(done), 32'd1);
    check_val("mfhi_busy_stall", 32'(n_stall), 32'd32);
    check_val("mfhi_busy_mddone", 32'(bus.MdDone), 32'd1);
    check_val("mfhi_busy_result", bus.Result, 32'd3);
    $display("md mfhi-while-busy Hi=%h stall=%0d", bus.Result, n_stall);

    // Reset in the middle of a run (counter = 10)
    drive(OP_MULT, 32'd5, 32'd6, 5'd0, 1'b1);
    @(negedge clk);
    drive(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    check_val("midrun_stall_before", 32'(bus.Stall), 32'd1);
    reset = 1'b1;
    #1;
    check_val("midrun_hi", bus.Hi, 32'd0);
    check_val("midrun_lo", bus.Lo, 32'd0);
    check_val("midrun_stall", 32'(bus.Stall), 32'd0);
    check_val("midrun_mddone", 32'(bus.MdDone), 32'd0);
    $display("reset mid-run Hi=%h Lo=%h Stall=%b", bus.Hi, bus.Lo, bus.Stall);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomized run: instructions held while stalled, with occasional
    // out-of-protocol changes while the engine is busy.
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!hold || $urandom_range(0, 15) == 0) begin
        bus.AluCtrl = rand_op();
        bus.A       = rand_operand();
        bus.B       = rand_operand();
        bus.Shamt   = 5'($urandom_range(0, 31));
        bus.MdValid = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      hold = bus.Stall;
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Execution-stage ALU of the single-cycle MIPS datapath.
- Consumes the 5-bit AluCtrl code produced by the ALU control decoder, plus the register-file and immediate operands.
- Single-cycle ops are combinational.
- mult/div run on an iterative 32-step engine that writes the HI/LO registers and raises Stall so the PC/IR hold until the result is ready.

Parameters:
WIDTH  32  datapath width; only 32 is supported (iteration counter is 5 bits, shift amounts are 5 bits).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
AluCtrl  input  5  operation code from the ALU control decoder
A  input  32  operand rs
B  input  32  operand rt or immediate
Shamt  input  5  instruction shift amount field
MdValid  input  1  instruction in execute is valid; qualifies mult/div issue
Result  output  32  ALU result (combinational)
Zero  output  1  Result == 0
BranchTaken  output  1  branch condition for beq/bne/blez/bgtz
Stall  output  1  hold the PC/IR this cycle
MdDone  output  1  one-cycle pulse when HI/LO are written
Hi  output  32  HI register
Lo  output  32  LO register

Behaviour:
- Reset is asynchronous, active-high. Clock is clk.
- Reset values: Hi=0, Lo=0, MdDone=0, internal busy=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts the operation; HI/LO return to 0.

Combinational Result by AluCtrl:
- 00000 and: A&B
- 00001 or: A|B
- 00010 add: A+B (wraps, no overflow trap)
- 00011 sub / beq: A-B
- 00100 xor: A^B
- 01111 nor: ~(A|B)
- 00101 sll: B<<Shamt
- 00110 srl: B>>Shamt (logical)
- 00111 sra: B>>>Shamt (arithmetic)
- 01011 sllv: B<<A[4:0]
- 01100 srlv: B>>A[4:0] (logical)
- 01000 slt: {31'b0, signed A<signed B}
- 01101 lui: {B[15:0],16'h0}
- 01010 mfhi: Hi
- 10011 mflo: Lo
- 10000 bne: A-B
- 10001 blez / 10010 bgtz: A
- 01001 mult / 01110 div: 0
- Any other code: Result=0.

BranchTaken:
- beq (00011): A==B
- bne: A!=B
- blez: signed A<=0
- bgtz: signed A>0
- Otherwise 0. Note: sub also asserts BranchTaken on equality; the control unit gates it with Branch.

Mult/div engine, states IDLE and RUN:
- Issue: in IDLE with MdValid=1 and AluCtrl in {mult, div}, the next edge latches |A|, |B|, the result signs and the op, clears counter, and enters RUN (busy=1).
- RUN: one shift-add (mult) or restoring-subtract (div) step per edge on magnitudes. At the edge where counter==31, write HI/LO, pulse MdDone=1 for one cycle, and return to IDLE.
- Busy is high for exactly 32 cycles. New HI/LO are visible on Hi/Lo and via mfhi/mflo in the cycle MdDone=1.
- mult is signed: {Hi,Lo} = signed A * signed B (64-bit), two's-complement corrected from the magnitude product.
- div is signed: Lo = quotient, truncated toward zero; Hi = remainder, sign of the dividend.
- Divide by zero: Hi=A, Lo=32'hFFFFFFFF; still takes 32 cycles, no exception.
- 0x80000000 / -1: Lo=0x80000000, Hi=0.
- Stall = (issue condition in IDLE) | (busy & ~(counter==31 edge pending)). Stall is high from the issue cycle through the last RUN cycle and low in the MdDone cycle, so the mult/div instruction retires exactly once.
- Stall is also high for mfhi/mflo/mult/div when busy. Stall is never high for other ops.
- mult/div presented while busy: not accepted; Stall held; it issues after completion. Under single-cycle hold semantics this cannot occur, but it must not corrupt the engine.
- MdValid=0 with a mult/div code: no issue, Stall=0.

Test Plan:
- Reset asserted mid-RUN (counter=10) -> Hi=Lo=0, Stall=0, MdDone=0 immediately, without waiting for a clock edge.
- ALU sweep: A=0xF0F0F0F0, B=0x0000FFFF -> and 0x0000F0F0, or 0xF0F0FFFF, nor 0x0F0F0000, xor 0xF0F00F0F.
- More ALU checks: lui B=0x1234 -> 0x12340000; sra B=0x80000000, Shamt=4 -> 0xF8000000; slt A=-1, B=1 -> 1.
- mult A=-3, B=7 with MdValid=1 -> Stall high for 32 cycles, MdDone on the 33rd edge after issue, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; then mflo returns 0xFFFFFFEB.
- div A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- div A=5, B=0 -> Hi=5, Lo=0xFFFFFFFF.
- div A=0x80000000, B=-1 -> Lo=0x80000000, Hi=0.
- Branches: A=B=9 beq -> BranchTaken=1, Zero=1; bne -> 0.
- More branches: A=0 blez -> 1, bgtz -> 0; A=0x80000000 bgtz -> 0.
- mfhi issued while busy -> Stall=1 until the MdDone cycle, then Result equals the new Hi.
